adder_seq_32: RTL
=================

# adder_seq_32

Multi-cycle 32-bit add/subtract sequencer that time-shares one existing 8-bit carry-lookahead slice (`cla_8`) across four cycles. It registers the operands and, for subtract, inverts B and seeds carry-in. It then steps the slice through bytes 0..3 with a registered inter-slice carry and presents the result plus ALU flags behind a valid/ready handshake. It sits beside the ALU as the low-area adder path.

## Interface
- `WIDTH`, 32: operand width; must be a multiple of 8.
- `NSLICE`, WIDTH/8: number of slice passes; derived, not overridden.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `in_valid`  in  1: request present.
- `in_ready`  out  1: block can accept; high only in IDLE.
- `data_operandA`  in  WIDTH: operand A.
- `data_operandB`  in  WIDTH: operand B.
- `ctrl_sub`  in  1: 0 = A+B, 1 = A−B.
- `out_valid`  out  1: result and flags valid; high only in DONE.
- `out_ready`  in  1: consumer takes the result.
- `data_result`  out  WIDTH: sum or difference.
- `carry_out`  out  1: final carry; for subtract, 1 means no borrow.
- `overflow`  out  1: signed overflow.
- `isNotEqual`  out  1: data_result ≠ 0.
- `isLessThan`  out  1: signed A < B; meaningful only when ctrl_sub = 1, else 0.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: `in_ready` = 1. On `in_valid`:
  - latch A and B' = B ^ {WIDTH{ctrl_sub}};
  - carry reg ← ctrl_sub; idx ← 0; latch ctrl_sub;
  - clear result reg; go to RUN.
- RUN, each cycle:
  - feed A[8·idx+:8], B'[8·idx+:8] and the carry reg to `cla_8`;
  - result[8·idx+:8] ← slice sum;
  - carry reg ← Gblock | (Pblock & carry);
  - idx ← idx+1.
  - When idx = NSLICE−1, go to DONE instead of incrementing.
- DONE:
  - `out_valid` = 1.
  - Flags computed from the registered result, A and B':
    - overflow = (A[MSB] == B'[MSB]) & (result[MSB] != A[MSB]);
    - isNotEqual = |result;
    - isLessThan = sub & (result[MSB] ^ overflow);
    - carry_out = carry reg.
  - On `out_ready`, go to IDLE.
- Arithmetic is modulo 2^WIDTH; no saturation.
- `in_valid` outside IDLE is ignored; no queuing.
- In DONE, `in_ready` = 0 even if `out_ready` = 1. A new request is accepted no earlier than the cycle after leaving DONE.
- Reset mid-RUN or in DONE aborts the operation. No partial result is ever presented.

## Timing
- Reset values: `in_ready` = 1; `out_valid` = 0; `data_result` = 0; `carry_out`, `overflow`, `isNotEqual`, `isLessThan` = 0. State = IDLE, idx = 0, carry reg = 0.
- Accept at edge t → slice k written at edge t+1+k → DONE entered at edge t+NSLICE (t+4 for 32 bits). `out_valid` is high in the cycle after edge t+4.
- With `out_ready` held high: DONE lasts 1 cycle and IDLE lasts at least 1 cycle, so the peak rate is one op per NSLICE+2 = 6 cycles.
- Outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- `data_result` and flags hold stable while `out_valid` = 1 and `out_ready` = 0. They are held after leaving DONE until the next accept clears them.

## Structure
- State encodings (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2) and SLICE_W = 8 go in the shared ALU defines include, reused by other sequenced ALU units.
- Exactly one sub-module: a single `cla_8` instance used every RUN cycle. The slice carry-out is reconstructed from Pblock/Gblock outside it.
- Byte select and write-back use the idx counter (width clog2(NSLICE)).

## Test plan
- Add 0x000000FF + 0x00000001:
  - `in_ready` drops the cycle after accept; `out_valid` appears 4 edges after accept;
  - result 0x00000100, carry_out 0, overflow 0.
- Add 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow 1, carry_out 0. Add 0xFFFFFFFF + 0x00000001 → result 0, carry_out 1, overflow 0.
- Sub 5 − 7 → 0xFFFFFFFE, isLessThan 1, isNotEqual 1, carry_out 0. Sub 0x80000000 − 1 → 0x7FFFFFFF, overflow 1, isLessThan 1.
- Sub 0x12345678 − 0x12345678 → result 0, isNotEqual 0, isLessThan 0, carry_out 1.
- Hold `out_ready` = 0 for 10 cycles while pulsing `in_valid` with new operands:
  - result and flags stay stable; `in_ready` stays 0; the pulses are not accepted;
  - after `out_ready`, one IDLE cycle occurs before the next accept.
- Assert `reset` while idx = 2 of an add:
  - all outputs go to reset values immediately, asynchronously;
  - after deassert, `in_ready` = 1 and a following 0x00010000 + 0x0000FFFF gives 0x0001FFFF.

Source files
------------

// File: rtl/adder_seq_32_pkg.sv
// Shared definitions for the sequenced ALU units: state encodings and slice width.
package adder_seq_32_pkg;

  localparam int unsigned SLICE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

endpackage : adder_seq_32_pkg

// File: rtl/adder_seq_32_cla_8.sv
// 8-bit carry-lookahead slice: sum plus group propagate/generate.
// The slice carry-out is rebuilt by the caller as g_block | (p_block & cin).
module cla_8
  import adder_seq_32_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum_c,
  output logic               p_block_c,
  output logic               g_block_c
);

  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic [SLICE_W:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  // Bit carries and group generate/propagate terms from the per-bit p/g.
  always_comb begin
    c         = '0;
    g_block_c = 1'b0;
    c[0]      = cin;
    for (int i = 0; i < int'(SLICE_W); i++) begin
      c[i+1]    = g[i] | (p[i] & c[i]);
      g_block_c = g[i] | (p[i] & g_block_c);
    end
    p_block_c = &p;
  end

  assign sum_c = p ^ c[SLICE_W-1:0];

endmodule : cla_8

// File: rtl/adder_seq_32.sv
// Multi-cycle add/subtract that steps one 8-bit CLA slice across the operand,
// one byte per cycle, with a registered inter-slice carry and a valid/ready result.
module adder_seq_32
  import adder_seq_32_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             carry_out,
  output logic             overflow,
  output logic             isNotEqual,
  output logic             isLessThan
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned MSB    = WIDTH - 1;

  seq_state_t         state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry_q;
  logic               sub_q;
  logic [IDX_W-1:0]   idx_q;

  logic [SLICE_W-1:0] slice_a_c;
  logic [SLICE_W-1:0] slice_b_c;
  logic [SLICE_W-1:0] slice_sum_c;
  logic               slice_p_c;
  logic               slice_g_c;
  logic               slice_cout_c;
  logic               last_c;
  logic               ovf_c;
  logic               ne_c;
  logic               lt_c;

  // Byte select for the current pass.
  assign slice_a_c = a_q[int'(idx_q)*int'(SLICE_W) +: SLICE_W];
  assign slice_b_c = b_q[int'(idx_q)*int'(SLICE_W) +: SLICE_W];

  cla_8 u_cla_8 (
    .a         (slice_a_c),
    .b         (slice_b_c),
    .cin       (carry_q),
    .sum_c     (slice_sum_c),
    .p_block_c (slice_p_c),
    .g_block_c (slice_g_c)
  );

  // Slice carry-out and flags for the final pass, where slice_sum_c is the top byte.
  assign slice_cout_c = slice_g_c | (slice_p_c & carry_q);
  assign last_c       = (idx_q == IDX_W'(NSLICE - 1));
  assign ovf_c        = (a_q[MSB] == b_q[MSB]) & (slice_sum_c[SLICE_W-1] != a_q[MSB]);
  assign ne_c         = (|slice_sum_c) | (|data_result[WIDTH-SLICE_W-1:0]);
  assign lt_c         = sub_q & (slice_sum_c[SLICE_W-1] ^ ovf_c);

  // Sequencer: accept, step the slice through each byte, hold result until taken.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      idx_q       <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      data_result <= '0;
      carry_out   <= 1'b0;
      overflow    <= 1'b0;
      isNotEqual  <= 1'b0;
      isLessThan  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q         <= data_operandA;
            b_q         <= data_operandB ^ {WIDTH{ctrl_sub}};
            carry_q     <= ctrl_sub;
            sub_q       <= ctrl_sub;
            idx_q       <= '0;
            data_result <= '0;
            carry_out   <= 1'b0;
            overflow    <= 1'b0;
            isNotEqual  <= 1'b0;
            isLessThan  <= 1'b0;
            in_ready    <= 1'b0;
            state_q     <= ST_RUN;
          end
        end
        ST_RUN: begin
          data_result[int'(idx_q)*int'(SLICE_W) +: SLICE_W] <= slice_sum_c;
          carry_q <= slice_cout_c;
          if (last_c) begin
            carry_out  <= slice_cout_c;
            overflow   <= ovf_c;
            isNotEqual <= ne_c;
            isLessThan <= lt_c;
            out_valid  <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : adder_seq_32
